truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
//
// PURPOSE
//   Drives every 2^N_IN input combination onto a combinational DUT in ascending order.
//   Captures the DUT's N_OUT response bits per vector into a packed truth-table word.
//   Optionally compares that word against an expected table and reports the first failing vector.
//   Sits beside small logic blocks as a reusable on-chip/bench stimulus-and-check engine.
//
// PARAMETERS
//   N_IN    3  number of DUT inputs; scan length 2^N_IN vectors (1..8)
//   N_OUT   1  number of DUT response bits captured per vector (1..8)
//   SETTLE  1  extra cycles each vector is held before sampling (0..15)
//
// PORTS
//   clk         in   1                 rising-edge clock
//   rst_n       in   1                 async active-low reset
//   start       in   1                 1-cycle request to begin a scan; honoured only in IDLE
//   cmp_en      in   1                 sampled with start; 1 = check against exp_table
//   exp_table   in   N_OUT*2^N_IN      expected table, same layout as table_out; must be stable while busy
//   vec_out     out  N_IN              vector driven to DUT inputs (MSB = first DUT input)
//   resp_in     in   N_OUT             DUT response for current vec_out
//   busy        out  1                 high from the cycle after start until done
//   done        out  1                 1-cycle pulse when the scan completes
//   table_out   out  N_OUT*2^N_IN      captured table; bit [v*N_OUT+k] = resp_in[k] at vector v
//   table_valid out  1                 table_out complete; held until next accepted start
//   mismatch    out  1                 compare failed; valid with table_valid
//   fail_idx    out  N_IN              lowest failing vector index; 0 if no mismatch
//
// BEHAVIOUR
//   Reset (async, any state): state = IDLE; all outputs 0.
//     vec_out, table_out, fail_idx, settle counter and vector counter are all cleared.
//     A reset mid-scan abandons the scan; no done pulse is issued.
//   FSM states are IDLE, APPLY, SAMPLE and FINISH.
//   IDLE:
//     On start=1: latch cmp_en; clear table_out, table_valid, mismatch, fail_idx, vec_out and the settle counter.
//     On the next edge: busy=1, state -> APPLY.
//   APPLY:
//     Hold vec_out for SETTLE cycles (settle counter 0..SETTLE-1), then -> SAMPLE.
//     With SETTLE=0, APPLY is skipped: IDLE goes straight to SAMPLE.
//   SAMPLE (one cycle):
//     Write resp_in into table_out slice vec_out.
//     If cmp_en is latched and resp_in != the exp_table slice, and mismatch is still 0:
//       set mismatch=1 and fail_idx=vec_out.
//     If vec_out == 2^N_IN-1 -> FINISH.
//     Otherwise vec_out += 1, clear the settle counter, and go to APPLY (or SAMPLE again if SETTLE=0).
//   FINISH (one cycle):
//     done=1, table_valid=1, busy=0, vec_out returns to 0, then -> IDLE.
//   Vector-counter width is N_IN bits; it never wraps mid-scan because termination is on all-ones.
//   Timing: each vector occupies SETTLE+1 cycles.
//     done is asserted 2^N_IN*(SETTLE+1)+1 cycles after the start cycle.
//   start while busy or in FINISH is ignored; it is not queued.
//   A start in the cycle after done is accepted normally.
//   With cmp_en=0, mismatch stays 0 and fail_idx stays 0.
//
// TESTING
//   1. N_IN=3, N_OUT=1, SETTLE=1, DUT = majority(a,b,c), start with cmp_en=0
//      -> vec_out steps 0..7, each held 2 cycles; done 17 cycles after start; table_out=8'hE8; busy low again.
//   2. Same DUT, cmp_en=1, exp_table=8'hE9
//      -> mismatch=1, fail_idx=3'd0. Repeat with exp_table=8'hE8 -> mismatch=0.
//   3. Assert start again at cycles 3 and 9 of an active scan
//      -> both ignored; exactly one done pulse; table_out=8'hE8.
//   4. Pull rst_n low at cycle 6 of a scan
//      -> immediately busy=0, vec_out=0, table_out=0; no done.
//      A new start after release gives a full correct scan.
//   5. N_IN=4, N_OUT=2, SETTLE=0, DUT = {xor4, and4}
//      -> done 17 cycles after start; table_out[v*2+1]=^v, table_out[v*2]=&v.
//      i.e. the xor bits read 16'h6996 and the and bits read 16'h8000.
//   6. Back-to-back: start in the cycle after done
//      -> accepted; table_valid drops at the accepting edge and re-asserts with the new done.

Source files
------------

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Steps a combinational block through every 2^N_IN input vector in
//   ascending order, captures N_OUT response bits per vector into a packed
//   truth table and optionally checks that table against an expected one,
//   reporting the lowest failing vector.
//
// Parameters
//   N_IN    number of DUT inputs (1..8); scan length is 2^N_IN vectors
//   N_OUT   response bits captured per vector (1..8)
//   SETTLE  extra cycles each vector is held before sampling (0..15)
//
// Ports
//   clk, rst_n   rising-edge clock, async active-low reset
//   start        1-cycle scan request, honoured only in IDLE
//   cmp_en       sampled with start; enables the compare against exp_table
//   exp_table    expected table, same layout as table_out; stable while busy
//   vec_out      vector driven onto the DUT inputs (MSB = first DUT input)
//   resp_in      DUT response to vec_out
//   busy         high while the scan is running
//   done         1-cycle pulse when the scan completes
//   table_out    captured table; bit [v*N_OUT+k] = resp_in[k] at vector v
//   table_valid  table_out complete; held until the next accepted start
//   mismatch     compare failed; valid with table_valid
//   fail_idx     lowest failing vector index, 0 when there is no mismatch
module truth_table_scanner #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cmp_en,
  input  logic [N_OUT*(2**N_IN)-1:0]    exp_table,
  output logic [N_IN-1:0]               vec_out,
  input  logic [N_OUT-1:0]              resp_in,
  output logic                          busy,
  output logic                          done,
  output logic [N_OUT*(2**N_IN)-1:0]    table_out,
  output logic                          table_valid,
  output logic                          mismatch,
  output logic [N_IN-1:0]               fail_idx
);

  localparam int unsigned TW = N_OUT * (2 ** N_IN);

  // Last settle count before sampling; unused when SETTLE is 0.
  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_FINISH
  } state_e;

  // With no settle time the APPLY state is bypassed entirely.
  localparam state_e S_VEC_ENTRY = (SETTLE == 0) ? S_SAMPLE : S_APPLY;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [3:0]        settle_q, settle_d;
  logic [TW-1:0]     table_q, table_d;
  logic              table_valid_q, table_valid_d;
  logic              mismatch_q, mismatch_d;
  logic [N_IN-1:0]   fail_idx_q, fail_idx_d;
  logic              cmp_en_q, cmp_en_d;

  // Current vector's slice of the expected table.
  logic [N_OUT-1:0]  exp_slice;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vec_q         <= '0;
      settle_q      <= '0;
      table_q       <= '0;
      table_valid_q <= 1'b0;
      mismatch_q    <= 1'b0;
      fail_idx_q    <= '0;
      cmp_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_q         <= vec_d;
      settle_q      <= settle_d;
      table_q       <= table_d;
      table_valid_q <= table_valid_d;
      mismatch_q    <= mismatch_d;
      fail_idx_q    <= fail_idx_d;
      cmp_en_q      <= cmp_en_d;
    end
  end

  always_comb begin
    exp_slice = exp_table[vec_q * N_OUT +: N_OUT];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    settle_d      = settle_q;
    table_d       = table_q;
    table_valid_d = table_valid_q;
    mismatch_d    = mismatch_q;
    fail_idx_d    = fail_idx_q;
    cmp_en_d      = cmp_en_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cmp_en_d      = cmp_en;
          table_d       = '0;
          table_valid_d = 1'b0;
          mismatch_d    = 1'b0;
          fail_idx_d    = '0;
          vec_d         = '0;
          settle_d      = '0;
          state_d       = S_VEC_ENTRY;
        end
      end

      S_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      S_SAMPLE: begin
        table_d[vec_q * N_OUT +: N_OUT] = resp_in;
        // Only the first failure is recorded, so fail_idx is the lowest one.
        if (cmp_en_q && (resp_in != exp_slice) && !mismatch_q) begin
          mismatch_d = 1'b1;
          fail_idx_d = vec_q;
        end
        if (vec_q == '1) begin
          // Table is complete as FINISH is entered; vector parks at 0.
          vec_d         = '0;
          table_valid_d = 1'b1;
          state_d       = S_FINISH;
        end else begin
          vec_d    = vec_q + N_IN'(1);
          settle_d = '0;
          state_d  = S_VEC_ENTRY;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy        = (state_q == S_APPLY) || (state_q == S_SAMPLE);
    done        = (state_q == S_FINISH);
    vec_out     = vec_q;
    table_out   = table_q;
    table_valid = table_valid_q;
    mismatch    = mismatch_q;
    fail_idx    = fail_idx_q;
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  logic        clk;
  logic        rst_n;

  // Instance 1: N_IN=3, N_OUT=1, SETTLE=1, DUT = majority(a,b,c)
  logic        start1, cmp_en1;
  logic [7:0]  exp1;
  logic [2:0]  vec1;
  logic [0:0]  resp1;
  logic        busy1, done1, tv1, mm1;
  logic [7:0]  table1;
  logic [2:0]  fidx1;

  // Instance 2: N_IN=4, N_OUT=2, SETTLE=0, DUT = {xor4, and4}
  logic        start2, cmp_en2;
  logic [31:0] exp2;
  logic [3:0]  vec2;
  logic [1:0]  resp2;
  logic        busy2, done2, tv2, mm2;
  logic [31:0] table2;
  logic [3:0]  fidx2;

  int n_cmp;
  int n_fail;

  truth_table_scanner #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmp_en(cmp_en1),
    .exp_table(exp1), .vec_out(vec1), .resp_in(resp1), .busy(busy1),
    .done(done1), .table_out(table1), .table_valid(tv1),
    .mismatch(mm1), .fail_idx(fidx1)
  );

  truth_table_scanner #(.N_IN(4), .N_OUT(2), .SETTLE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cmp_en(cmp_en2),
    .exp_table(exp2), .vec_out(vec2), .resp_in(resp2), .busy(busy2),
    .done(done2), .table_out(table2), .table_valid(tv2),
    .mismatch(mm2), .fail_idx(fidx2)
  );

  // Combinational blocks under test.
  always_comb begin
    resp1[0] = (vec1[2] & vec1[1]) | (vec1[2] & vec1[0]) | (vec1[1] & vec1[0]);
    resp2    = {^vec2, &vec2};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after a rising edge (cycle 0); returns #1 into cycle 1.
  task automatic pulse_start1(input logic cmp, input logic [7:0] exp);
    cmp_en1 = cmp;
    exp1    = exp;
    start1  = 1'b1;
    @(posedge clk); #1;
    start1  = 1'b0;
  endtask

  // Runs from cycle 1 for up to 'limit' cycles, optionally injecting start
  // pulses at cycles inj_a/inj_b. When stop_at_done is set it returns in the
  // done cycle. first_done is the cycle of the first done pulse, -1 if none.
  task automatic run1(input int limit, input int inj_a, input int inj_b,
                      input bit stop_at_done,
                      output int first_done, output int n_done);
    int cnt;
    cnt = 1;
    first_done = -1;
    n_done = 0;
    while (cnt <= limit) begin
      if (done1) begin
        n_done++;
        if (first_done < 0) first_done = cnt;
        if (stop_at_done) break;
      end
      start1 = (cnt == inj_a) || (cnt == inj_b);
      @(posedge clk); #1;
      start1 = 1'b0;
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if ({busy1, done1, tv1, mm1} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl1: got %b expected 0000", {busy1, done1, tv1, mm1}); end
    n_cmp++; if ({vec1, table1, fidx1} !== 14'h0) begin n_fail++; $display("FAIL reset_data1: got %h expected 0", {vec1, table1, fidx1}); end
    n_cmp++; if ({busy2, done2, tv2, mm2, vec2, table2, fidx2} !== 44'h0) begin n_fail++; $display("FAIL reset_dut2: got %h expected 0", {busy2, done2, tv2, mm2, vec2, table2, fidx2}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_scan_nocmp();
    int cnt;
    pulse_start1(1'b0, 8'h00);
    cnt = 1;
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b expected 1", busy1); end
    while (!done1 && cnt < 60) begin
      if (cnt <= 16) begin
        n_cmp++;
        if (vec1 !== 3'((cnt - 1) / 2)) begin n_fail++; $display("FAIL vec_step c%0d: got %0d expected %0d", cnt, vec1, (cnt - 1) / 2); end
      end
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++; if (!done1 || cnt != 17) begin n_fail++; $display("FAIL done_latency: got %0d expected 17", cnt); end
    n_cmp++; if (table1 !== 8'hE8) begin n_fail++; $display("FAIL maj_table: got %h expected e8", table1); end
    n_cmp++; if ({tv1, busy1, mm1, fidx1} !== 6'b100000) begin n_fail++; $display("FAIL finish_flags: got %b expected 100000", {tv1, busy1, mm1, fidx1}); end
    @(posedge clk); #1;
    n_cmp++; if ({done1, busy1, vec1, tv1} !== 6'b000001) begin n_fail++; $display("FAIL after_done: got %b expected 000001", {done1, busy1, vec1, tv1}); end
  endtask

  task automatic test_compare();
    int fd, nd;
    pulse_start1(1'b1, 8'hE9);
    run1(40, -1, -1, 1'b1, fd, nd);
    n_cmp++; if (fd != 17) begin n_fail++; $display("FAIL cmp_latency: got %0d expected 17", fd); end
    n_cmp++; if ({mm1, fidx1} !== 4'b1000) begin n_fail++; $display("FAIL cmp_e9: got %b expected 1000", {mm1, fidx1}); end
    @(posedge clk); #1;
    pulse_start1(1'b1, 8'hE8);
    run1(40, -1, -1, 1'b1, fd, nd);
    n_cmp++; if ({tv1, mm1, fidx1} !== 5'b10000) begin n_fail++; $display("FAIL cmp_e8: got %b expected 10000", {tv1, mm1, fidx1}); end
    @(posedge clk); #1;
    // Differs at vectors 3 and 6; the lowest must be reported.
    pulse_start1(1'b1, 8'hA0);
    run1(40, -1, -1, 1'b1, fd, nd);
    n_cmp++; if ({mm1, fidx1} !== 4'b1011) begin n_fail++; $display("FAIL cmp_first: got %b expected 1011", {mm1, fidx1}); end
    @(posedge clk); #1;
    pulse_start1(1'b1, 8'h68);
    run1(40, -1, -1, 1'b1, fd, nd);
    n_cmp++; if ({mm1, fidx1} !== 4'b1111) begin n_fail++; $display("FAIL cmp_last: got %b expected 1111", {mm1, fidx1}); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int fd, nd;
    pulse_start1(1'b0, 8'h00);
    run1(40, 3, 9, 1'b0, fd, nd);
    n_cmp++; if (nd != 1 || fd != 17) begin n_fail++; $display("FAIL ignore_start: got %0d dones first %0d expected 1 first 17", nd, fd); end
    n_cmp++; if ({table1, busy1} !== 9'h1D0) begin n_fail++; $display("FAIL ignore_table: got %h expected 1d0", {table1, busy1}); end
  endtask

  task automatic test_mid_reset();
    int fd, nd;
    pulse_start1(1'b1, 8'hFF);
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if ({busy1, mm1, vec1} !== 5'b11010) begin n_fail++; $display("FAIL pre_reset: got %b expected 11010", {busy1, mm1, vec1}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy1, done1, tv1, mm1, vec1, table1} !== 15'h0) begin n_fail++; $display("FAIL mid_reset: got %h expected 0", {busy1, done1, tv1, mm1, vec1, table1}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run1(30, -1, -1, 1'b0, fd, nd);
    n_cmp++; if (nd != 0) begin n_fail++; $display("FAIL reset_no_done: got %0d expected 0", nd); end
    pulse_start1(1'b0, 8'h00);
    run1(40, -1, -1, 1'b1, fd, nd);
    n_cmp++; if (fd != 17 || table1 !== 8'hE8) begin n_fail++; $display("FAIL rescan: got %0d/%h expected 17/e8", fd, table1); end
    @(posedge clk); #1;
  endtask

  task automatic test_wide_nosettle();
    int cnt;
    logic [15:0] xr, ar, xg, ag;
    xr = 16'h6996;
    ar = 16'h8000;
    for (int v = 0; v < 16; v++) begin
      exp2[2*v+1] = xr[v];
      exp2[2*v]   = ar[v];
    end
    cmp_en2 = 1'b1;
    start2  = 1'b1;
    @(posedge clk); #1;
    start2  = 1'b0;
    cnt = 1;
    while (!done2 && cnt < 60) begin
      if (cnt <= 16) begin
        n_cmp++;
        if (vec2 !== 4'(cnt - 1)) begin n_fail++; $display("FAIL vec2_step c%0d: got %0d expected %0d", cnt, vec2, cnt - 1); end
      end
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++; if (!done2 || cnt != 17) begin n_fail++; $display("FAIL done2_latency: got %0d expected 17", cnt); end
    for (int v = 0; v < 16; v++) begin
      xg[v] = table2[2*v+1];
      ag[v] = table2[2*v];
    end
    n_cmp++; if (xg !== 16'h6996) begin n_fail++; $display("FAIL xor_bits: got %h expected 6996", xg); end
    n_cmp++; if (ag !== 16'h8000) begin n_fail++; $display("FAIL and_bits: got %h expected 8000", ag); end
    n_cmp++; if ({tv2, mm2, fidx2} !== 6'b100000) begin n_fail++; $display("FAIL wide_flags: got %b expected 100000", {tv2, mm2, fidx2}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int fd, nd;
    pulse_start1(1'b0, 8'h00);
    run1(40, -1, -1, 1'b1, fd, nd);
    @(posedge clk); #1;
    n_cmp++; if ({tv1, done1} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle: got %b expected 10", {tv1, done1}); end
    pulse_start1(1'b1, 8'hE8);
    n_cmp++; if ({tv1, busy1} !== 2'b01) begin n_fail++; $display("FAIL b2b_accept: got %b expected 01", {tv1, busy1}); end
    run1(40, -1, -1, 1'b1, fd, nd);
    n_cmp++; if (fd != 17 || tv1 !== 1'b1 || table1 !== 8'hE8 || mm1 !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got %0d/%b/%h/%b expected 17/1/e8/0", fd, tv1, table1, mm1); end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    start1 = 1'b0; cmp_en1 = 1'b0; exp1 = '0;
    start2 = 1'b0; cmp_en2 = 1'b0; exp2 = '0;
    test_reset();
    test_scan_nocmp();
    test_compare();
    test_start_ignored();
    test_mid_reset();
    test_wide_nosettle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
